rect_loop_sched: RTL and testbench
==================================

Name: rect_loop_sched

Overview:
- Sequencing controller for the 4x4 rectangle-flip datapath.
- Accepts a 16-bit binary matrix over a valid/ready handshake, then sweeps every axis-aligned rectangle (r1<r2, c1<c2) one per clock.
- For each rectangle whose four corners form a checkerboard, it XORs the corners. Row and column sums are preserved.
- Returns the updated matrix and a flip count over a valid/ready output handshake. It sits between the matrix source (testbench/host) and downstream sampling logic.

Parameters:
- ROWS, 4, matrix rows; only 4 is supported, elaborate-time assert.
- COLS, 4, matrix columns; only 4 is supported, elaborate-time assert.
- CHECK_EN, 1, 1 = flip only checkerboard rectangles; 0 = flip every rectangle unconditionally (debug/verification mode).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source presents matrix plus sweep count.
- in_ready  output  1  block can accept a load.
- m_in  input  16  matrix, row-major, cell (r,c) at bit 15-(r*COLS+c). (0,0) is the MSB.
- n_sweeps  input  8  number of full sweeps; latched on load.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts result.
- m_out  output  16  result matrix, same bit layout as m_in.
- flip_count  output  16  number of rectangles flipped during the job; saturates at 16'hFFFF.
- busy  output  1  high while in RUN.

Behaviour:
- Reset: asynchronous on rst_n low. Forces state IDLE, m_out=0, flip_count=0, out_valid=0, busy=0, all counters 0. in_ready=1 while in IDLE.
- Reset asserted mid-RUN or mid-DONE aborts the job. No result is produced.
- States:
  - IDLE: in_ready=1.
  - RUN: busy=1, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE -> RUN: on in_valid&&in_ready at edge T.
  - Latch m_in into the matrix register and n_sweeps into the sweep counter.
  - Clear flip_count and the rectangle index.
  - If n_sweeps=0, go to DONE directly instead. m_out=m_in, flip_count=0, out_valid high in cycle T+1.
- RUN: one rectangle evaluated per cycle.
  - Enumeration order: r1 outer, then r2, then c1, then c2 innermost. Only r1<r2 and c1<c2 are visited, giving 6x6 = 36 rectangles per sweep.
  - The first rectangle is (0,1,0,1) and the last is (2,3,2,3).
- Checkerboard condition: m[r1][c1]==m[r2][c2] && m[r1][c2]==m[r2][c1] && m[r1][c1]!=m[r1][c2].
- Flip: the matrix register is updated with matrix ^ mask4 at the end of the evaluation cycle, and flip_count increments. The next rectangle sees the updated matrix (strictly sequential, no lookahead).
- When CHECK_EN=0, the condition is forced true.
- Sweep wrap:
  - After rectangle 35, the index returns to 0 and the sweep counter decrements.
  - When the last sweep's rectangle 35 completes, go to DONE.
  - Total RUN length is exactly 36*n_sweeps cycles; out_valid first rises at cycle T+1+36*n_sweeps.
- DONE:
  - m_out and flip_count are held stable and out_valid is held high until out_ready.
  - On out_valid&&out_ready, go to IDLE. in_ready is high the following cycle; no same-cycle reload.
  - out_ready high before DONE has no effect.
  - in_valid is ignored outside IDLE.
- m_out is a registered copy of the matrix register, updated continuously. It is only meaningful while out_valid=1.
- Width rules:
  - Rectangle index is 6 bits, compared against 35.
  - Sweep counter is 8 bits.
  - flip_count holds at 16'hFFFF instead of wrapping. The maximum real job is 255*36 = 9180 flips, so saturation is a guard only.

Decomposition:
- Package rect_loop_pkg:
  - ROWS and COLS constants.
  - N_RECT=36.
  - State enum {IDLE, RUN, DONE}.
  - A cell_bit(r,c) function returning 15-(r*COLS+c).
  - A rect_t struct holding r1, r2, c1, c2 (2 bits each).
- Sub-module rect_corner_flip (combinational):
  - Inputs: matrix, rect_t, check_en.
  - Outputs: is_checker, mask (4 one-hot corner bits OR-ed), flipped matrix.
  - The scheduler instantiates it once.
- Rectangle enumeration is a small counter plus a 36-entry constant lookup, or nested counters, kept in the top level.

Test Plan:
- Reset then load m_in=16'h0000, n_sweeps=1, CHECK_EN=0 -> out_valid at T+37, m_out=16'hFFFF (each cell is a corner of 9 rectangles), flip_count=36.
- Same stimulus with n_sweeps=2, CHECK_EN=0 -> out_valid at T+73, m_out=16'h0000, flip_count=72.
- CHECK_EN=1, m_in=16'h8400, n_sweeps=1 -> m_out=16'h4800, flip_count=1. With n_sweeps=2 -> m_out=16'h8400, flip_count=2. Row and column sums are equal to the input in both cases.
- m_in=16'hA5C3, n_sweeps=0 -> out_valid at T+1, m_out=16'hA5C3, flip_count=0. m_in=16'h0000 or 16'hFFFF with n_sweeps=3, CHECK_EN=1 -> unchanged, flip_count=0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, m_out and flip_count stable. in_valid pulses during RUN/DONE are ignored. After the accept, in_ready=1 on the next cycle.
- Assert rst_n low 5 cycles into RUN -> outputs immediately at reset values, state IDLE. A new load then completes normally with the expected result.

Source files
------------

// File: rtl/rect_loop_sched_pkg.sv
// Shared types and constants for the 4x4 rectangle-flip scheduler.
package rect_loop_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned MW     = ROWS * COLS;
    localparam int unsigned N_RECT = 36;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned SWP_W  = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [1:0] r1;
        logic [1:0] r2;
        logic [1:0] c1;
        logic [1:0] c2;
    } rect_t;

    // Row-major layout with cell (0,0) at the MSB.
    function automatic logic [3:0] cell_bit(input logic [1:0] r, input logic [1:0] c);
        return 4'(MW - 1 - (32'(r) * COLS + 32'(c)));
    endfunction

    // Rectangle index -> corners: r1 outer, r2, c1, c2 innermost.
    function automatic rect_t rect_lut(input logic [IDX_W-1:0] idx);
        rect_t       rect;
        int unsigned k;
        rect = '0;
        k    = 0;
        for (int unsigned r1 = 0; r1 < ROWS; r1++) begin
            for (int unsigned r2 = r1 + 1; r2 < ROWS; r2++) begin
                for (int unsigned c1 = 0; c1 < COLS; c1++) begin
                    for (int unsigned c2 = c1 + 1; c2 < COLS; c2++) begin
                        if (IDX_W'(k) == idx) begin
                            rect = '{r1: 2'(r1), r2: 2'(r2), c1: 2'(c1), c2: 2'(c2)};
                        end
                        k++;
                    end
                end
            end
        end
        return rect;
    endfunction

endpackage

// File: rtl/rect_loop_sched_if.sv
// Load/result handshake bundle between the matrix source, scheduler and sink.
interface rect_loop_sched_if;
    import rect_loop_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [MW-1:0]    m_in;
    logic [SWP_W-1:0] n_sweeps;
    logic             out_valid;
    logic             out_ready;
    logic [MW-1:0]    m_out;
    logic [CNT_W-1:0] flip_count;
    logic             busy;

    modport slave (
        input  in_valid, m_in, n_sweeps, out_ready,
        output in_ready, out_valid, m_out, flip_count, busy
    );

    modport master (
        output in_valid, m_in, n_sweeps, out_ready,
        input  in_ready, out_valid, m_out, flip_count, busy
    );

endinterface

// File: rtl/rect_loop_sched_corner_flip.sv
// Combinational corner test and XOR of one rectangle's four corners.
module rect_corner_flip
    import rect_loop_pkg::*;
(
    input  logic [MW-1:0] matrix,
    input  rect_t         rect,
    input  logic          check_en,
    output logic          is_checker,
    output logic [MW-1:0] mask,
    output logic [MW-1:0] flipped
);

    logic [3:0] b11, b12, b21, b22;

    always_comb begin
        b11 = cell_bit(rect.r1, rect.c1);
        b12 = cell_bit(rect.r1, rect.c2);
        b21 = cell_bit(rect.r2, rect.c1);
        b22 = cell_bit(rect.r2, rect.c2);

        mask      = '0;
        mask[b11] = 1'b1;
        mask[b12] = 1'b1;
        mask[b21] = 1'b1;
        mask[b22] = 1'b1;

        // Diagonals equal and differing from each other: a 2x2 checkerboard.
        is_checker = check_en ? ((matrix[b11] == matrix[b22]) &&
                                 (matrix[b12] == matrix[b21]) &&
                                 (matrix[b11] != matrix[b12]))
                              : 1'b1;
        flipped = is_checker ? (matrix ^ mask) : matrix;
    end

endmodule

// File: rtl/rect_loop_sched.sv
// Sweeps all 36 rectangles of a 4x4 binary matrix, flipping checkerboard corners,
// one rectangle per clock for n_sweeps sweeps.
module rect_loop_sched
    import rect_loop_pkg::MW, rect_loop_pkg::IDX_W, rect_loop_pkg::SWP_W,
           rect_loop_pkg::CNT_W, rect_loop_pkg::N_RECT, rect_loop_pkg::state_t,
           rect_loop_pkg::IDLE, rect_loop_pkg::RUN, rect_loop_pkg::DONE,
           rect_loop_pkg::rect_t, rect_loop_pkg::rect_lut;
#(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter bit          CHECK_EN = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    rect_loop_sched_if.slave bus
);

    if (ROWS != 4 || COLS != 4) begin : g_bad_geometry
        $error("rect_loop_sched supports only a 4x4 matrix");
    end

    state_t           state, state_d;
    logic [MW-1:0]    matrix, matrix_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [SWP_W-1:0] sweeps, sweeps_d;
    logic [CNT_W-1:0] flip_cnt, flip_cnt_d;
    logic [MW-1:0]    m_out_q;
    logic             in_ready_q, out_valid_q, busy_q;

    rect_t            rect;
    logic             is_checker;
    logic [MW-1:0]    mask, flipped;

    assign rect = rect_lut(idx);

    rect_corner_flip u_flip (
        .matrix     (matrix),
        .rect       (rect),
        .check_en   (1'(CHECK_EN)),
        .is_checker (is_checker),
        .mask       (mask),
        .flipped    (flipped)
    );

    // Next state, matrix, sweep bookkeeping and saturating flip count.
    always_comb begin
        state_d    = state;
        matrix_d   = matrix;
        idx_d      = idx;
        sweeps_d   = sweeps;
        flip_cnt_d = flip_cnt;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    matrix_d   = bus.m_in;
                    sweeps_d   = bus.n_sweeps;
                    flip_cnt_d = '0;
                    idx_d      = '0;
                    state_d    = (bus.n_sweeps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                matrix_d = flipped;
                if (is_checker && (flip_cnt != '1)) begin
                    flip_cnt_d = flip_cnt + CNT_W'(1);
                end
                if (idx == IDX_W'(N_RECT - 1)) begin
                    idx_d    = '0;
                    sweeps_d = sweeps - SWP_W'(1);
                    if (sweeps == SWP_W'(1)) begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            matrix      <= '0;
            idx         <= '0;
            sweeps      <= '0;
            flip_cnt    <= '0;
            m_out_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            matrix      <= matrix_d;
            idx         <= idx_d;
            sweeps      <= sweeps_d;
            flip_cnt    <= flip_cnt_d;
            m_out_q     <= matrix_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == RUN);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.m_out      = m_out_q;
    assign bus.flip_count = flip_cnt;

endmodule

// File: tb/tb_rect_loop_sched.sv
// Scoreboard bench: one checkerboard-mode and one flip-all instance share the stimulus.
module tb_rect_loop_sched;

    typedef struct {
        logic [15:0] m_in;
        logic [15:0] m_exp;
        logic [15:0] fc_exp;
        int          lat_exp;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] m_in = '0;
    logic [7:0]  n_sweeps = '0;
    logic        out_ready = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    exp_t sbq [2][$];

    logic        rise_seen [2] = '{1'b0, 1'b0};
    int          rise_cyc  [2] = '{0, 0};
    logic [15:0] rise_m    [2] = '{16'h0, 16'h0};
    logic [15:0] rise_fc   [2] = '{16'h0, 16'h0};

    rect_loop_sched_if chk_if ();
    rect_loop_sched_if dbg_if ();

    assign chk_if.in_valid  = in_valid;
    assign chk_if.m_in      = m_in;
    assign chk_if.n_sweeps  = n_sweeps;
    assign chk_if.out_ready = out_ready;
    assign dbg_if.in_valid  = in_valid;
    assign dbg_if.m_in      = m_in;
    assign dbg_if.n_sweeps  = n_sweeps;
    assign dbg_if.out_ready = out_ready;

    rect_loop_sched #(.ROWS(4), .COLS(4), .CHECK_EN(1'b1)) u_chk (
        .clk(clk), .rst_n(rst_n), .bus(chk_if.slave));
    rect_loop_sched #(.ROWS(4), .COLS(4), .CHECK_EN(1'b0)) u_dbg (
        .clk(clk), .rst_n(rst_n), .bus(dbg_if.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Four row popcounts in the low nibbles, four column popcounts above.
    function automatic logic [31:0] line_sums(input logic [15:0] m);
        logic [31:0] s;
        s = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m[15 - (r * 4 + c)]) begin
                    s[r * 4 +: 4]      = s[r * 4 +: 4] + 4'd1;
                    s[16 + c * 4 +: 4] = s[16 + c * 4 +: 4] + 4'd1;
                end
        return s;
    endfunction

    task automatic mon(input int w, input logic ov, input logic ordy,
                       input logic [15:0] m, input logic [15:0] fc);
        exp_t  e;
        string tag;
        tag = (w == 0) ? "chk" : "dbg";
        if (!rst_n) begin
            rise_seen[w] = 1'b0;
        end else begin
            if (ov && !rise_seen[w]) begin
                rise_seen[w] = 1'b1;
                rise_cyc[w]  = cyc;
                rise_m[w]    = m;
                rise_fc[w]   = fc;
            end
            if (ov && ordy) begin
                rise_seen[w] = 1'b0;
                if (sbq[w].size() == 0) begin
                    check({tag, " unexpected result"}, 32'(1), 32'(0));
                end else begin
                    e = sbq[w].pop_front();
                    check({tag, " m_out"}, 32'(m), 32'(e.m_exp));
                    check({tag, " flip_count"}, 32'(fc), 32'(e.fc_exp));
                    check({tag, " latency"}, 32'(rise_cyc[w] - e.acc), 32'(e.lat_exp));
                    check({tag, " held stable"}, {m, fc}, {rise_m[w], rise_fc[w]});
                    if (w == 0) check({tag, " line sums"}, line_sums(m), line_sums(e.m_in));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, chk_if.out_valid, out_ready, chk_if.m_out, chk_if.flip_count);
        mon(1, dbg_if.out_valid, out_ready, dbg_if.m_out, dbg_if.flip_count);
    end

    // Flip-all mode toggles every cell 9 times per sweep and counts 36 flips per sweep.
    task automatic run_job(input logic [15:0] m, input logic [7:0] n,
                           input logic [15:0] chk_m, input logic [15:0] chk_fc,
                           input int hold, input bit early);
        exp_t e;
        int   t;
        t = 0;
        while (!(chk_if.in_ready && dbg_if.in_ready) && t < 200) begin
            @(posedge clk); #2; t++;
        end
        check("in_ready before load", 32'(chk_if.in_ready && dbg_if.in_ready), 32'(1));
        m_in = m; n_sweeps = n; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        // out_valid is visible after edge acc + 36*n, i.e. cycle T+1+36n.
        e = '{m_in: m, m_exp: chk_m, fc_exp: chk_fc, lat_exp: 36 * int'(n), acc: cyc};
        sbq[0].push_back(e);
        e.m_exp  = n[0] ? ~m : m;
        e.fc_exp = 16'(36 * int'(n));
        sbq[1].push_back(e);
        check("busy after load", 32'(chk_if.busy), 32'(n != 0));
        check("in_ready after load", 32'(chk_if.in_ready), 32'(0));
        if (early) out_ready = 1'b1;
        m_in = 16'h1234; n_sweeps = 8'd5; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        t = 0;
        while (!(chk_if.out_valid && dbg_if.out_valid) && t < 36 * int'(n) + 20) begin
            @(posedge clk); #2; t++;
        end
        if (!(chk_if.out_valid && dbg_if.out_valid)) begin
            check("out_valid timeout", 32'(0), 32'(1));
            out_ready = 1'b0;
            return;
        end
        if (!early) begin
            in_valid = 1'b1;
            repeat (hold + 1) begin @(posedge clk); #2; in_valid = 1'b0; end
            out_ready = 1'b1;
        end
        @(posedge clk); #2;
        out_ready = 1'b0;
        check("in_ready after accept", 32'(chk_if.in_ready && dbg_if.in_ready), 32'(1));
        check("out_valid after accept", 32'(chk_if.out_valid || dbg_if.out_valid), 32'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset in_ready", 32'(chk_if.in_ready), 32'(1));
        check("reset outputs", {chk_if.m_out, chk_if.flip_count}, 32'(0));
        check("reset valid/busy", {30'd0, chk_if.out_valid, chk_if.busy}, 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #2;

        run_job(16'h0000, 8'd1, 16'h0000, 16'd0, 10, 1'b0);
        run_job(16'h0000, 8'd2, 16'h0000, 16'd0, 0, 1'b0);
        run_job(16'h8400, 8'd1, 16'h4800, 16'd1, 2, 1'b1);
        run_job(16'h8400, 8'd2, 16'h8400, 16'd2, 0, 1'b0);
        run_job(16'hA5C3, 8'd0, 16'hA5C3, 16'd0, 3, 1'b0);
        run_job(16'hFFFF, 8'd3, 16'hFFFF, 16'd0, 0, 1'b0);

        // Abort a job five cycles into RUN.
        m_in = 16'h8400; n_sweeps = 8'd2; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("busy mid-run", 32'(chk_if.busy && dbg_if.busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort chk outputs", {chk_if.m_out, chk_if.flip_count}, 32'(0));
        check("abort dbg outputs", {dbg_if.m_out, dbg_if.flip_count}, 32'(0));
        check("abort flags", {29'd0, chk_if.in_ready, chk_if.out_valid, chk_if.busy}, 32'(4));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        run_job(16'h8400, 8'd1, 16'h4800, 16'd1, 0, 1'b0);
        run_job(16'h0000, 8'd3, 16'h0000, 16'd0, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard drained", 32'(sbq[0].size() + sbq[1].size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
